ahbl_mem_wb: RTL and testbench
==============================

AHBL_MEM_WB -- requirements
Module: ahbl_mem_wb

Interface
REQ-001 Parameter MEM_AW, default 12, SHALL give byte-address width of the array (2^MEM_AW bytes, 2^(MEM_AW-2) 32-bit words), legal range 4..20.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, SHALL give the first byte address decoded; it must be 2^MEM_AW aligned.
REQ-003 Parameter RD_WAIT, default 0, SHALL give extra read data-phase wait states, legal range 0..3.
REQ-004 HCLK  in  1  sole clock; all state on rising edge.
REQ-005 HRESET  in  1  reset, synchronous, active-high.
REQ-006 HSEL  in  1  slave select.
REQ-007 HADDR  in  32  byte address, address phase.
REQ-008 HTRANS  in  2  transfer type; bit 1 set = NONSEQ/SEQ.
REQ-009 HWRITE  in  1  1 = write.
REQ-010 HSIZE  in  3  0 byte, 1 half, 2 word; others illegal.
REQ-011 HWDATA  in  32  write data, data phase.
REQ-012 HREADY  in  1  bus ready; address phase accepted only when 1.
REQ-013 HREADYOUT  out  1  slave ready.
REQ-014 HRESP  out  1  1 = ERROR.
REQ-015 HRDATA  out  32  read data, registered.

Function
REQ-016 Transfer SHALL be accepted at an edge where HSEL & HTRANS[1] & HREADY; address-phase signals are registered only then.
REQ-017 Access SHALL be illegal if HADDR outside BASE_ADDR..BASE_ADDR+2^MEM_AW-1, HSIZE>2, halfword with HADDR[0]=1, or word with HADDR[1:0]!=0.
REQ-018 Illegal access SHALL give two-cycle ERROR (cycle 1: HRESP=1, HREADYOUT=0; cycle 2: HRESP=1, HREADYOUT=1), with no array access and no buffer change.
REQ-019 Byte strobes SHALL decode from registered HSIZE and HADDR[1:0]: byte -> one lane, half -> lanes 1:0 or 3:2, word -> all four.
REQ-020 Writes SHALL be zero-wait: at the edge ending the write data phase, word address, strobes and HWDATA load a one-entry write buffer.
REQ-021 Buffer SHALL drain to the array at any edge where no array read is launched; drain and new load at the same edge are allowed.
REQ-022 Reads SHALL launch the array read at the accepting edge; data phase lasts 1+RD_WAIT cycles with HREADYOUT=0 for the first RD_WAIT.
REQ-023 Buffer-to-read forwarding SHALL compare the buffer state after the launch edge with the read word address, register hit strobes and data, and drive HRDATA as the array word with hit lanes replaced.
REQ-024 Hazard: buffer valid and unable to drain because a write data phase ends at the edge a read is accepted SHALL drain the old entry at that edge, defer read launch one edge, and add one wait state (HREADYOUT=0).
REQ-025 FSM states IDLE, RD_DATA, RD_DEFER, ERR1, ERR2; IDLE->RD_DATA/RD_DEFER/ERR1 on accept; RD_DEFER->RD_DATA; RD_DATA->IDLE or next-transfer state when wait count reaches 0; ERR1->ERR2->IDLE/next.
REQ-026 HREADYOUT=1, HRESP=0 in IDLE and for writes; HRDATA holds last read value outside read data phases.
REQ-027 Word index SHALL be HADDR[MEM_AW-1:2]; no wrap past top, out-of-range handled by REQ-018.

Reset
REQ-028 HRESET SHALL force state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, buffer invalid, wait counter 0, registered address-phase signals cleared.
REQ-029 Reset mid-transfer SHALL discard any pending buffer entry and abort the data phase; array contents are undefined-preserved (not cleared).

Structure
REQ-030 Package ahbl_mem_pkg SHALL hold HTRANS/HSIZE encodings, FSM state enum, and the strobe-decode function.
REQ-031 Sub-module ahbl_mem_sram SHALL hold the single-port byte-writable array with synchronous read, one read or one write per cycle.

Verification
REQ-032 Word write 32'hDEADBEEF to BASE+0x10, then read -> HRDATA=32'hDEADBEEF, HREADYOUT never 0 with RD_WAIT=0.
REQ-033 Write byte 8'hA5 to BASE+0x13 then immediate read BASE+0x10 (word previously 32'h11223344) -> 32'hA5223344 via forwarding.
REQ-034 Write BASE+0x0, write BASE+0x4, read BASE+0x0 back-to-back -> exactly one wait cycle on read, correct data.
REQ-035 Read BASE+2^MEM_AW, and word read at BASE+0x2 -> two-cycle ERROR each, HRESP=1 both cycles, array unchanged.
REQ-036 RD_WAIT=2, read -> HREADYOUT low 2 cycles then data; assert HRESET during wait -> next cycle HREADYOUT=1, HRDATA=0, pending write lost.

Source files
------------

// File: rtl/ahbl_mem_pkg.sv
// ahbl_mem_pkg -- shared definitions for the AHB-Lite write-buffered memory.
//   * HTRANS / HSIZE encodings
//   * read/error FSM state enum
//   * byte-strobe decode and size/alignment legality helpers
package ahbl_mem_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_DATA,
        ST_RD_DEFER,
        ST_ERR1,
        ST_ERR2
    } state_t;

    // Little-endian byte lanes: byte -> one lane, half -> 1:0 or 3:2, word -> all.
    function automatic logic [3:0] strb_decode(input logic [2:0] size, input logic [1:0] a);
        logic [3:0] s;
        s = 4'b0000;
        case (size)
            HSIZE_BYTE: s = 4'b0001 << a;
            HSIZE_HALF: s = a[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: s = 4'b1111;
            default:    s = 4'b0000;
        endcase
        return s;
    endfunction

    // Size is supported and the address is naturally aligned for it.
    function automatic logic size_aligned(input logic [2:0] size, input logic [1:0] a);
        logic ok;
        ok = 1'b0;
        case (size)
            HSIZE_BYTE: ok = 1'b1;
            HSIZE_HALF: ok = ~a[0];
            HSIZE_WORD: ok = (a == 2'b00);
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ahbl_mem_wb_if.sv
// ahbl_mem_wb_if -- AHB-Lite slave-side bus bundle.
//   master modport: drives address/control/write data and HREADY.
//   slave modport : drives HREADYOUT, HRESP, HRDATA.
interface ahbl_mem_wb_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahbl_mem_sram.sv
// ahbl_mem_sram -- single-port byte-writable 32-bit array, synchronous read.
//   clk_i   : clock
//   re_i    : read enable, data appears on rdata_o after the edge and holds
//   we_i    : write enable (takes priority; caller never asserts both)
//   addr_i  : word index
//   be_i    : byte lane enables for writes
//   wdata_i : write data
//   rdata_o : last read word
module ahbl_mem_sram #(
    parameter int unsigned AW = 10
) (
    input  logic          clk_i,
    input  logic          re_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [3:0]    be_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);
    logic [3:0][7:0] mem_q [2**AW];
    logic [31:0]     rdata_q;

    // No reset: array and read register keep contents across HRESET.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) mem_q[addr_i][i] <= wdata_i[8*i +: 8];
            end
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/ahbl_mem_wb.sv
// ahbl_mem_wb -- AHB-Lite memory slave with a one-entry write buffer.
//   HCLK   : clock
//   HRESET : synchronous active-high reset
//   bus    : AHB-Lite slave modport (HSEL..HREADY in, HREADYOUT/HRESP/HRDATA out)
// Writes are zero-wait: write data is parked in the buffer at the end of the
// data phase and drained to the array on the next edge with no read launch.
// Reads launch at the accepting edge and forward buffered bytes into HRDATA.
module ahbl_mem_wb #(
    parameter int unsigned MEM_AW    = 12,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned RD_WAIT   = 0
) (
    input  logic         HCLK,
    input  logic         HRESET,
    ahbl_mem_wb_if.slave bus
);
    import ahbl_mem_pkg::*;

    localparam int unsigned WAW       = MEM_AW - 2;
    localparam logic [1:0]  WAIT_INIT = 2'(RD_WAIT);

    state_t            state_q;
    logic              hready_q, hresp_q;
    logic [1:0]        cnt_q;
    logic [MEM_AW-1:0] haddr_q;
    logic [2:0]        hsize_q;
    logic              wr_dp_q;
    logic [31:0]       hrdata_q;

    logic              wb_vld_q, wb_vld_d;
    logic [WAW-1:0]    wb_addr_q, wb_addr_d;
    logic [3:0]        wb_strb_q, wb_strb_d;
    logic [31:0]       wb_data_q, wb_data_d;

    logic [3:0]        fwd_strb_q;
    logic [31:0]       fwd_data_q;

    logic              acc, legal, hazard, rd_now, rd_launch, drain, fwd_hit;
    logic [WAW-1:0]    rd_word;
    logic [31:0]       sram_rdata, rd_merged;
    logic              unused_htrans0;

    assign unused_htrans0 = bus.HTRANS[0];

    // hready_q is high exactly when the current data phase (if any) ends at
    // this edge, so gating with it keeps a foreign HREADY from starting a
    // transfer while this slave is still mid-phase.
    assign acc    = bus.HSEL & bus.HTRANS[1] & bus.HREADY & hready_q;
    assign legal  = (bus.HADDR[31:MEM_AW] == BASE_ADDR[31:MEM_AW])
                  & size_aligned(bus.HSIZE, bus.HADDR[1:0]);

    // A read accepted while a write data phase ends and the buffer is still
    // full: the array port is needed to drain, so the read slips one edge.
    assign hazard    = acc & legal & ~bus.HWRITE & wb_vld_q & wr_dp_q;
    assign rd_now    = acc & legal & ~bus.HWRITE & ~hazard;
    assign rd_launch = rd_now | (state_q == ST_RD_DEFER);
    assign rd_word   = (state_q == ST_RD_DEFER) ? haddr_q[MEM_AW-1:2] : bus.HADDR[MEM_AW-1:2];
    assign drain     = wb_vld_q & ~rd_launch;

    always_comb begin
        wb_vld_d  = wb_vld_q;
        wb_addr_d = wb_addr_q;
        wb_strb_d = wb_strb_q;
        wb_data_d = wb_data_q;
        if (drain) wb_vld_d = 1'b0;
        if (wr_dp_q) begin
            wb_vld_d  = 1'b1;
            wb_addr_d = haddr_q[MEM_AW-1:2];
            wb_strb_d = strb_decode(hsize_q, haddr_q[1:0]);
            wb_data_d = bus.HWDATA;
        end
    end

    // Forwarding looks at the buffer as it will be after the launch edge.
    assign fwd_hit = wb_vld_d & (wb_addr_d == rd_word);

    ahbl_mem_sram #(.AW(WAW)) u_sram (
        .clk_i   (HCLK),
        .re_i    (rd_launch & ~HRESET),
        .we_i    (drain & ~HRESET),
        .addr_i  (rd_launch ? rd_word : wb_addr_q),
        .be_i    (wb_strb_q),
        .wdata_i (wb_data_q),
        .rdata_o (sram_rdata)
    );

    always_comb begin
        rd_merged = sram_rdata;
        for (int i = 0; i < 4; i++) begin
            if (fwd_strb_q[i]) rd_merged[8*i +: 8] = fwd_data_q[8*i +: 8];
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q    <= ST_IDLE;
            hready_q   <= 1'b1;
            hresp_q    <= 1'b0;
            cnt_q      <= '0;
            haddr_q    <= '0;
            hsize_q    <= '0;
            wr_dp_q    <= 1'b0;
            hrdata_q   <= '0;
            wb_vld_q   <= 1'b0;
            wb_addr_q  <= '0;
            wb_strb_q  <= '0;
            wb_data_q  <= '0;
            fwd_strb_q <= '0;
            fwd_data_q <= '0;
        end else begin
            wb_vld_q  <= wb_vld_d;
            wb_addr_q <= wb_addr_d;
            wb_strb_q <= wb_strb_d;
            wb_data_q <= wb_data_d;
            wr_dp_q   <= 1'b0;

            if (rd_launch) begin
                fwd_strb_q <= fwd_hit ? wb_strb_d : 4'b0000;
                fwd_data_q <= wb_data_d;
            end

            if (hready_q) begin
                // Current data phase ends here; hold the read value after it.
                if (state_q == ST_RD_DATA) hrdata_q <= rd_merged;
                state_q  <= ST_IDLE;
                hready_q <= 1'b1;
                hresp_q  <= 1'b0;
                if (acc) begin
                    haddr_q <= bus.HADDR[MEM_AW-1:0];
                    hsize_q <= bus.HSIZE;
                    if (!legal) begin
                        state_q  <= ST_ERR1;
                        hready_q <= 1'b0;
                        hresp_q  <= 1'b1;
                    end else if (bus.HWRITE) begin
                        wr_dp_q <= 1'b1;
                    end else if (hazard) begin
                        state_q  <= ST_RD_DEFER;
                        hready_q <= 1'b0;
                    end else begin
                        state_q  <= ST_RD_DATA;
                        cnt_q    <= WAIT_INIT;
                        hready_q <= (WAIT_INIT == 2'd0);
                    end
                end
            end else begin
                case (state_q)
                    ST_RD_DEFER: begin
                        state_q  <= ST_RD_DATA;
                        cnt_q    <= WAIT_INIT;
                        hready_q <= (WAIT_INIT == 2'd0);
                    end
                    ST_RD_DATA: begin
                        cnt_q    <= cnt_q - 2'd1;
                        hready_q <= (cnt_q == 2'd1);
                    end
                    ST_ERR1: begin
                        state_q  <= ST_ERR2;
                        hready_q <= 1'b1;
                    end
                    default: begin
                        state_q  <= ST_IDLE;
                        hready_q <= 1'b1;
                        hresp_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.HREADYOUT = hready_q;
    assign bus.HRESP     = hresp_q;
    assign bus.HRDATA    = (state_q == ST_RD_DATA) ? rd_merged : hrdata_q;
endmodule

// File: tb/tb_ahbl_mem_wb.sv
// tb_ahbl_mem_wb -- directed bench for ahbl_mem_wb.
//   u_dut0: RD_WAIT=0, u_dut1: RD_WAIT=2; both decode BASE 0x1000, 4 KiB.
module tb_ahbl_mem_wb;
    import ahbl_mem_pkg::*;

    logic clk = 1'b0;
    logic rst0, rst1;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    ahbl_mem_wb_if b0();
    ahbl_mem_wb_if b1();

    assign b0.HREADY = b0.HREADYOUT;
    assign b1.HREADY = b1.HREADYOUT;

    ahbl_mem_wb #(.MEM_AW(12), .BASE_ADDR(32'h0000_1000), .RD_WAIT(0)) u_dut0 (
        .HCLK(clk), .HRESET(rst0), .bus(b0)
    );
    ahbl_mem_wb #(.MEM_AW(12), .BASE_ADDR(32'h0000_1000), .RD_WAIT(2)) u_dut1 (
        .HCLK(clk), .HRESET(rst1), .bus(b1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a0(input logic w, input logic [31:0] a, input logic [2:0] sz);
        b0.HSEL = 1'b1; b0.HTRANS = HTRANS_NONSEQ; b0.HWRITE = w; b0.HADDR = a; b0.HSIZE = sz;
    endtask
    task automatic i0();
        b0.HSEL = 1'b0; b0.HTRANS = HTRANS_IDLE;
    endtask
    task automatic a1(input logic w, input logic [31:0] a, input logic [2:0] sz);
        b1.HSEL = 1'b1; b1.HTRANS = HTRANS_NONSEQ; b1.HWRITE = w; b1.HADDR = a; b1.HSIZE = sz;
    endtask
    task automatic i1();
        b1.HSEL = 1'b0; b1.HTRANS = HTRANS_IDLE;
    endtask

    // Write then idle two edges so the buffer loads and drains.
    task automatic wr0(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
        a0(1'b1, a, sz); tick(); i0(); b0.HWDATA = d; tick(); tick();
    endtask

    // Zero-wait read on dut0 with data checked in its single data cycle.
    task automatic rd0(input string tag, input logic [31:0] a, input logic [31:0] exp);
        a0(1'b0, a, HSIZE_WORD); tick(); i0();
        chk({tag, "_rdy"}, 32'(b0.HREADYOUT), 32'd1);
        chk(tag, b0.HRDATA, exp);
        tick();
    endtask

    // Two-cycle error response on dut0.
    task automatic err0(input string tag, input logic w, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] hold);
        a0(w, a, sz); tick(); i0(); b0.HWDATA = 32'hFFFF_FFFF;
        chk({tag, "_e1_resp"}, 32'(b0.HRESP), 32'd1);
        chk({tag, "_e1_rdy"}, 32'(b0.HREADYOUT), 32'd0);
        tick();
        chk({tag, "_e2_resp"}, 32'(b0.HRESP), 32'd1);
        chk({tag, "_e2_rdy"}, 32'(b0.HREADYOUT), 32'd1);
        chk({tag, "_hold"}, b0.HRDATA, hold);
        tick();
        chk({tag, "_done_resp"}, 32'(b0.HRESP), 32'd0);
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1;
        b0.HSEL = 1'b0; b0.HADDR = '0; b0.HTRANS = HTRANS_IDLE; b0.HWRITE = 1'b0;
        b0.HSIZE = HSIZE_WORD; b0.HWDATA = '0;
        b1.HSEL = 1'b0; b1.HADDR = '0; b1.HTRANS = HTRANS_IDLE; b1.HWRITE = 1'b0;
        b1.HSIZE = HSIZE_WORD; b1.HWDATA = '0;
        tick(); tick();
        rst0 = 1'b0; rst1 = 1'b0;

        chk("rst_rdy", 32'(b0.HREADYOUT), 32'd1);
        chk("rst_resp", 32'(b0.HRESP), 32'd0);
        chk("rst_rdata", b0.HRDATA, 32'd0);
        chk("rst1_rdy", 32'(b1.HREADYOUT), 32'd1);

        // Word write immediately followed by read: forwarded, no wait.
        a0(1'b1, 32'h0000_1010, HSIZE_WORD); tick();
        b0.HWDATA = 32'hDEAD_BEEF; a0(1'b0, 32'h0000_1010, HSIZE_WORD);
        chk("wr_dp_rdy", 32'(b0.HREADYOUT), 32'd1);
        tick(); i0();
        chk("fwd_word_rdy", 32'(b0.HREADYOUT), 32'd1);
        chk("fwd_word", b0.HRDATA, 32'hDEAD_BEEF);
        tick();
        chk("rdata_hold", b0.HRDATA, 32'hDEAD_BEEF);
        tick();
        rd0("arr_word", 32'h0000_1010, 32'hDEAD_BEEF);

        // Byte write to lane 3 then immediate read: lane forwarded over array.
        wr0(32'h0000_1010, HSIZE_WORD, 32'h1122_3344);
        a0(1'b1, 32'h0000_1013, HSIZE_BYTE); tick();
        b0.HWDATA = 32'hA500_0000; a0(1'b0, 32'h0000_1010, HSIZE_WORD);
        tick(); i0();
        chk("fwd_byte_rdy", 32'(b0.HREADYOUT), 32'd1);
        chk("fwd_byte", b0.HRDATA, 32'hA522_3344);
        tick(); tick();
        rd0("arr_byte", 32'h0000_1010, 32'hA522_3344);
        wr0(32'h0000_1012, HSIZE_HALF, 32'h7788_0000);
        rd0("arr_half", 32'h0000_1010, 32'h7788_3344);

        // Write, write, read back-to-back: one deferral wait state.
        a0(1'b1, 32'h0000_1000, HSIZE_WORD); tick();
        b0.HWDATA = 32'h0A0A_0A0A; a0(1'b1, 32'h0000_1004, HSIZE_WORD);
        tick();
        b0.HWDATA = 32'h0B0B_0B0B; a0(1'b0, 32'h0000_1000, HSIZE_WORD);
        chk("ww_rdy", 32'(b0.HREADYOUT), 32'd1);
        tick(); i0();
        chk("defer_wait", 32'(b0.HREADYOUT), 32'd0);
        tick();
        chk("defer_rdy", 32'(b0.HREADYOUT), 32'd1);
        chk("defer_data", b0.HRDATA, 32'h0A0A_0A0A);
        tick(); tick();
        rd0("arr_w4", 32'h0000_1004, 32'h0B0B_0B0B);

        // Illegal accesses: two-cycle ERROR, array untouched.
        err0("oob_rd", 1'b0, 32'h0000_2000, HSIZE_WORD, 32'h0B0B_0B0B);
        err0("mis_rd", 1'b0, 32'h0000_1002, HSIZE_WORD, 32'h0B0B_0B0B);
        err0("mis_wr", 1'b1, 32'h0000_1006, HSIZE_WORD, 32'h0B0B_0B0B);
        err0("bad_sz", 1'b1, 32'h0000_1004, 3'd3, 32'h0B0B_0B0B);
        tick();
        rd0("err_keep0", 32'h0000_1000, 32'h0A0A_0A0A);
        rd0("err_keep4", 32'h0000_1004, 32'h0B0B_0B0B);

        // RD_WAIT=2: two low cycles then data.
        a1(1'b1, 32'h0000_1020, HSIZE_WORD); tick();
        i1(); b1.HWDATA = 32'h1234_5678; tick(); tick();
        a1(1'b0, 32'h0000_1020, HSIZE_WORD); tick(); i1();
        chk("w2_c1", 32'(b1.HREADYOUT), 32'd0);
        tick();
        chk("w2_c2", 32'(b1.HREADYOUT), 32'd0);
        tick();
        chk("w2_c3", 32'(b1.HREADYOUT), 32'd1);
        chk("w2_data", b1.HRDATA, 32'h1234_5678);
        tick();

        // Reset during the wait discards the buffered write.
        a1(1'b1, 32'h0000_1020, HSIZE_WORD); tick();
        b1.HWDATA = 32'hCAFE_F00D; a1(1'b0, 32'h0000_1024, HSIZE_WORD);
        tick(); i1();
        chk("w2r_wait", 32'(b1.HREADYOUT), 32'd0);
        rst1 = 1'b1;
        tick();
        chk("mid_rst_rdy", 32'(b1.HREADYOUT), 32'd1);
        chk("mid_rst_rdata", b1.HRDATA, 32'd0);
        chk("mid_rst_resp", 32'(b1.HRESP), 32'd0);
        rst1 = 1'b0;
        tick();
        a1(1'b0, 32'h0000_1020, HSIZE_WORD); tick(); i1();
        tick(); tick();
        chk("lost_rdy", 32'(b1.HREADYOUT), 32'd1);
        chk("lost_wr", b1.HRDATA, 32'h1234_5678);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
